// File: rtl/ecg_pkg.sv
// ---------------------------------------------------------------------------
// ecg_pkg
// Shared constants and types for the ECG moving-average block.
//   ADC_W_DFLT : default ADC sample width (MCP3202 = 12 bits)
//   MIDSCALE   : ADC code representing 0 V differential (used by the
//                optional DC-offset removal, ECG_DC_OFFSET_EN)
//   ecg_state_e: sequencing states of the averaging FSM
// ---------------------------------------------------------------------------
package ecg_pkg;

    localparam int ADC_W_DFLT = 12;
    localparam int MIDSCALE   = 1 << (ADC_W_DFLT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_ACC  = 2'd2,
        S_OUT  = 2'd3
    } ecg_state_e;

endpackage

// File: rtl/ecg_sample_avg_if.sv
// ---------------------------------------------------------------------------
// ecg_sample_avg_if
// Valid/ready stream carrying averaged ECG samples to the next stage.
//   out_data  : averaged sample (producer -> consumer)
//   out_valid : out_data holds an unconsumed result (producer -> consumer)
//   out_ready : consumer accepts when out_valid & out_ready (consumer -> producer)
// Modports: master = producer (ecg_sample_avg), slave = consumer.
// ---------------------------------------------------------------------------
interface ecg_sample_avg_if
    import ecg_pkg::*;
#(
    parameter int ADC_W = ADC_W_DFLT
);

    logic [ADC_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/ecg_ring_buf.sv
// ---------------------------------------------------------------------------
// ecg_ring_buf
// Circular buffer holding the last 2^AVG_LOG2 ADC samples.
//   clk, rst_n : clock, asynchronous active-low reset (contents zeroed)
//   rd_en      : load rd_data with the entry at the write pointer, i.e. the
//                oldest sample, which is the one about to be replaced
//   rd_data    : registered read data
//   wr_en      : write wr_data at the write pointer and advance it (wraps)
//   wr_data    : sample to store
// ---------------------------------------------------------------------------
module ecg_ring_buf #(
    parameter int ADC_W    = 12,
    parameter int AVG_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rd_en,
    output logic [ADC_W-1:0] rd_data,
    input  logic             wr_en,
    input  logic [ADC_W-1:0] wr_data
);

    localparam int N = 1 << AVG_LOG2;

    logic [ADC_W-1:0]    mem_q [N];
    logic [ADC_W-1:0]    mem_d [N];
    logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADC_W-1:0]    rd_data_q, rd_data_d;

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[wr_ptr_q];
        end
        if (wr_en) begin
            mem_d[wr_ptr_q] = wr_data;
            // Pointer width is exactly AVG_LOG2, so the increment wraps mod N.
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ecg_sample_avg.sv
// ---------------------------------------------------------------------------
// ecg_sample_avg
// Moving average over 2^AVG_LOG2 ADC samples taken from the MCP3202 SPI
// master's level-style data/dv outputs, presented on a valid/ready stream.
//   clk, rst_n : clock, asynchronous active-low reset
//   adc_data   : ADC sample, stable while adc_dv is high
//   adc_dv     : level sample-valid; each rising edge is one new sample
//   out_if     : master side of ecg_sample_avg_if (out_data/out_valid/out_ready)
//   overrun    : sticky, a result was overwritten unread or a sample dropped
//   warm       : the window has been filled since reset
// Optional build macro ECG_DC_OFFSET_EN: out_data becomes the two's-complement
// average with MIDSCALE subtracted (midscale code maps to 0).
// Each sample takes four cycles: detect/capture, read oldest, accumulate and
// write back, publish.
// ---------------------------------------------------------------------------
module ecg_sample_avg
    import ecg_pkg::*;
#(
    parameter int ADC_W    = ADC_W_DFLT,
    parameter int AVG_LOG2 = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADC_W-1:0]        adc_data,
    input  logic                    adc_dv,
    ecg_sample_avg_if.master        out_if,
    output logic                    overrun,
    output logic                    warm
);

    localparam int SUM_W = ADC_W + AVG_LOG2;
    // Fill count saturates at N, which needs AVG_LOG2+1 bits.
    localparam logic [AVG_LOG2:0] N_CNT = {1'b1, {AVG_LOG2{1'b0}}};
`ifdef ECG_DC_OFFSET_EN
    localparam logic [ADC_W-1:0] MID = {1'b1, {(ADC_W-1){1'b0}}};
`endif

    ecg_state_e          state_q, state_d;
    logic                dv_q, dv_d;
    logic [ADC_W-1:0]    smp_q, smp_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [AVG_LOG2:0]   fill_q, fill_d;
    logic [ADC_W-1:0]    out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                overrun_q, overrun_d;
    logic                warm_q, warm_d;

    logic                new_smp;
    logic                load;
    logic [ADC_W-1:0]    old_smp;
    logic [ADC_W-1:0]    avg;
    logic [ADC_W-1:0]    result;

    ecg_ring_buf #(
        .ADC_W    (ADC_W),
        .AVG_LOG2 (AVG_LOG2)
    ) u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_en   (state_q == S_READ),
        .rd_data (old_smp),
        .wr_en   (state_q == S_ACC),
        .wr_data (smp_q)
    );

    // dv_q resets high so a dv already asserted out of reset is not a sample.
    assign new_smp = adc_dv & ~dv_q;
    assign load    = (state_q == S_OUT) && (fill_q == N_CNT);
    assign avg     = sum_q[SUM_W-1:AVG_LOG2];

`ifdef ECG_DC_OFFSET_EN
    assign result = avg - MID;
`else
    assign result = avg;
`endif

    always_comb begin
        dv_d        = adc_dv;
        state_d     = state_q;
        smp_d       = smp_q;
        sum_d       = sum_q;
        fill_d      = fill_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        warm_d      = warm_q;

        case (state_q)
            S_IDLE: begin
                if (new_smp) begin
                    smp_d   = adc_data;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                state_d = S_ACC;
            end
            S_ACC: begin
                // Sum of the window can never exceed N * max code, so SUM_W
                // bits always hold it; the intermediate wrap cancels out.
                sum_d = sum_q + SUM_W'(smp_q) - SUM_W'(old_smp);
                if (fill_q != N_CNT) begin
                    fill_d = fill_q + 1'b1;
                end
                state_d = S_OUT;
            end
            S_OUT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A sample arriving while the previous one is still in flight is lost.
        if (new_smp && (state_q != S_IDLE)) begin
            overrun_d = 1'b1;
        end

        if (out_valid_q && out_if.out_ready) begin
            out_valid_d = 1'b0;
        end
        // A load wins over a same-edge accept, so valid stays high.
        if (load) begin
            out_data_d  = result;
            out_valid_d = 1'b1;
            warm_d      = 1'b1;
            if (out_valid_q && !out_if.out_ready) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dv_q        <= 1'b1;
            smp_q       <= '0;
            sum_q       <= '0;
            fill_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
            warm_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dv_q        <= dv_d;
            smp_q       <= smp_d;
            sum_q       <= sum_d;
            fill_q      <= fill_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
            warm_q      <= warm_d;
        end
    end

    assign out_if.out_data  = out_data_q;
    assign out_if.out_valid = out_valid_q;
    assign overrun          = overrun_q;
    assign warm             = warm_q;

endmodule
